// File: rtl/bus_xfer_if.sv
// Purpose : Request and strobe bundle between a bus transfer requester (the
//           control FSM or a testbench) and bus_xfer_ctrl.
// Signals :
//   req_valid/req_ready   request handshake. A request transfers on a rising
//                         edge where both are 1. The requester holds req_*
//                         stable while req_valid=1. The controller captures
//                         req_* at that edge and never samples them again.
//                         req_ready is 1 only while the controller is idle.
//   req_op/src/dst/data   operation, endpoint indices and load data
//   out_sel/in_sel        one-hot source / destination enables (NSEL bits)
//   Read/Mdatain          MDR input mux select and memory data
//   done/err              completion / rejection pulses
//   xfer_count            completed-transfer counter
//   dbg_state             controller state encoding, for observation only
interface bus_xfer_if #(
    parameter int NSEL = 27
) ();
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [4:0]      req_src;
    logic [4:0]      req_dst;
    logic [31:0]     req_data;
    logic [NSEL-1:0] out_sel;
    logic [NSEL-1:0] in_sel;
    logic            Read;
    logic [31:0]     Mdatain;
    logic            done;
    logic            err;
    logic [15:0]     xfer_count;
    logic [2:0]      dbg_state;

    modport master (
        output req_valid, req_op, req_src, req_dst, req_data,
        input  req_ready, out_sel, in_sel, Read, Mdatain, done, err,
               xfer_count, dbg_state
    );

    modport slave (
        input  req_valid, req_op, req_src, req_dst, req_data,
        output req_ready, out_sel, in_sel, Read, Mdatain, done, err,
               xfer_count, dbg_state
    );
endinterface

// File: rtl/bus_xfer_ctrl.sv
// Purpose : Bus transfer sequencer. Accepts one request at a time and drives
//           the one-hot source (*out) and destination (*in) strobes that move
//           one word across BusMuxOut. It also sequences the two-step memory
//           load path: Mdatain into MDR, then MDR onto the bus to the
//           destination.
// Ports   :
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    bus_xfer_if.slave. It carries the request handshake, the strobes,
//          Read/Mdatain, done/err, xfer_count and dbg_state.
// Options : define BUS_XFER_COUNT_EN to build the completed-transfer counter.
//           When it is undefined, xfer_count is tied to 0.
// Outputs are all registered. Each state's strobes are loaded on the edge
// that enters that state, so they are valid for the whole state cycle.
module bus_xfer_ctrl #(
    parameter int NSEL    = 27,
    parameter int MDR_IDX = 22
) (
    input logic      clk,
    input logic      reset,
    bus_xfer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MOVE  = 3'd1,
        S_DRIVE = 3'd2,
        S_LOADA = 3'd3,
        S_LOADB = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [1:0]      OP_MOVE  = 2'b00;
    localparam logic [1:0]      OP_LOAD  = 2'b01;
    localparam logic [1:0]      OP_DRIVE = 2'b10;
    localparam logic [NSEL-1:0] ONE      = {{(NSEL-1){1'b0}}, 1'b1};
    localparam logic [4:0]      MDR_SEL  = 5'(MDR_IDX);

    state_t          state_q;
    logic [4:0]      dst_q;
    logic            ready_q;
    logic [NSEL-1:0] out_sel_q;
    logic [NSEL-1:0] in_sel_q;
    logic            read_q;
    logic [31:0]     mdatain_q;
    logic            done_q;
    logic            err_q;

    // Index range checks. An index field that the op does not use is
    // ignored further down.
    logic src_ok;
    logic dst_ok;
    assign src_ok = (32'(bus.req_src) < 32'(NSEL));
    assign dst_ok = (32'(bus.req_dst) < 32'(NSEL));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            dst_q     <= '0;
            ready_q   <= 1'b1;
            out_sel_q <= '0;
            in_sel_q  <= '0;
            read_q    <= 1'b0;
            mdatain_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // Strobes and pulses last one cycle unless the next state sets them.
            out_sel_q <= '0;
            in_sel_q  <= '0;
            read_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // ready_q is always 1 in IDLE, so req_valid alone accepts.
                    if (bus.req_valid) begin
                        ready_q <= 1'b0;
                        dst_q   <= bus.req_dst;
                        if (bus.req_op == OP_MOVE && src_ok && dst_ok) begin
                            state_q   <= S_MOVE;
                            out_sel_q <= ONE << bus.req_src;
                            in_sel_q  <= ONE << bus.req_dst;
                            done_q    <= 1'b1;
                        end else if (bus.req_op == OP_DRIVE && src_ok) begin
                            state_q   <= S_DRIVE;
                            out_sel_q <= ONE << bus.req_src;
                            done_q    <= 1'b1;
                        end else if (bus.req_op == OP_LOAD && dst_ok) begin
                            state_q   <= S_LOADA;
                            read_q    <= 1'b1;
                            mdatain_q <= bus.req_data;
                            in_sel_q  <= ONE << MDR_IDX;
                            // A load whose destination is MDR finishes in LOADA.
                            done_q    <= (bus.req_dst == MDR_SEL);
                        end else begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                S_LOADA: begin
                    if (dst_q == MDR_SEL) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        state_q   <= S_LOADB;
                        out_sel_q <= ONE << MDR_IDX;
                        in_sel_q  <= ONE << dst_q;
                        done_q    <= 1'b1;
                    end
                end
                default: begin
                    // MOVE, DRIVE, LOADB and ERR each last a single cycle.
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef BUS_XFER_COUNT_EN
    logic [15:0] count_q;
    // The count advances on the edge that closes a done cycle. It wraps
    // naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (done_q) begin
            count_q <= count_q + 16'd1;
        end
    end
    assign bus.xfer_count = count_q;
`else
    assign bus.xfer_count = '0;
`endif

    assign bus.req_ready = ready_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.in_sel    = in_sel_q;
    assign bus.Read      = read_q;
    assign bus.Mdatain   = mdatain_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_bus_xfer_ctrl.sv
module tb_bus_xfer_ctrl;
  localparam int NSEL = 27;
  localparam int MDR  = 22;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_xfer_if #(.NSEL(NSEL)) bus ();

  bus_xfer_ctrl #(.NSEL(NSEL), .MDR_IDX(MDR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // One strobe cycle, as seen on the outputs.
  typedef struct packed {
    logic [NSEL-1:0] out_sel;
    logic [NSEL-1:0] in_sel;
    logic            rd;
    logic            done;
    logic            err;
  } cyc_t;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  src;
    logic [4:0]  dst;
    logic [31:0] data;
    int          ncyc;
    cyc_t        c0;
    cyc_t        c1;
    logic [31:0] mdat;
  } vec_t;

  cyc_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_mdat;
  logic [15:0] exp_count;
  vec_t        tbl[13];

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [NSEL-1:0] bit_at(input int i);
    logic [NSEL-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic cyc_t mk(input logic [NSEL-1:0] o, input logic [NSEL-1:0] i,
                              input logic rd, input logic dn, input logic er);
    cyc_t c;
    c.out_sel = o; c.in_sel = i; c.rd = rd; c.done = dn; c.err = er;
    return c;
  endfunction

  // Reference model: a request expands into the list of strobe cycles it
  // must produce.
  task automatic model(input logic [1:0] op, input logic [4:0] src,
                       input logic [4:0] dst, input logic [31:0] data);
    bit s_ok, d_ok;
    s_ok = int'(src) < NSEL;
    d_ok = int'(dst) < NSEL;
    if (op == 2'd0 && s_ok && d_ok) begin
      exp_q.push_back(mk(bit_at(src), bit_at(dst), 0, 1, 0));
    end else if (op == 2'd2 && s_ok) begin
      exp_q.push_back(mk(bit_at(src), '0, 0, 1, 0));
    end else if (op == 2'd1 && d_ok) begin
      exp_mdat = data;
      exp_q.push_back(mk('0, bit_at(MDR), 1, int'(dst) == MDR, 0));
      if (int'(dst) != MDR) exp_q.push_back(mk(bit_at(MDR), bit_at(dst), 0, 1, 0));
    end else begin
      exp_q.push_back(mk('0, '0, 0, 0, 1));
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " idle ready"},   64'(bus.req_ready), 64'd1);
    chk({tag, " idle out_sel"}, 64'(bus.out_sel), 64'd0);
    chk({tag, " idle in_sel"},  64'(bus.in_sel), 64'd0);
    chk({tag, " idle Read"},    64'(bus.Read), 64'd0);
    chk({tag, " idle done"},    64'(bus.done), 64'd0);
    chk({tag, " idle err"},     64'(bus.err), 64'd0);
    chk({tag, " idle Mdatain"}, 64'(bus.Mdatain), 64'(exp_mdat));
    chk({tag, " xfer_count"},   64'(bus.xfer_count), 64'(exp_count));
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1. Issues a request, then checks it against exp_q.
  task automatic run_req(input string tag, input logic [1:0] op, input logic [4:0] src,
                         input logic [4:0] dst, input logic [31:0] data);
    int   t;
    int   n;
    cyc_t c;
    t = 0;
    while (bus.req_ready !== 1'b1 && t < 10) begin
      @(posedge clk); #1; t++;
    end
    if (t == 10) chk({tag, " ready timeout"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_src = src;
    bus.req_dst = dst; bus.req_data = data;
    @(posedge clk); #1;
    // Scramble the request fields to show they are not sampled again.
    bus.req_valid = 1'b0; bus.req_op = 2'($urandom); bus.req_src = 5'($urandom);
    bus.req_dst = 5'($urandom); bus.req_data = $urandom;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      c = exp_q.pop_front();
      chk($sformatf("%s c%0d out_sel", tag, i), 64'(bus.out_sel), 64'(c.out_sel));
      chk($sformatf("%s c%0d in_sel", tag, i),  64'(bus.in_sel), 64'(c.in_sel));
      chk($sformatf("%s c%0d Read", tag, i),    64'(bus.Read), 64'(c.rd));
      chk($sformatf("%s c%0d done", tag, i),    64'(bus.done), 64'(c.done));
      chk($sformatf("%s c%0d err", tag, i),     64'(bus.err), 64'(c.err));
      chk($sformatf("%s c%0d ready", tag, i),   64'(bus.req_ready), 64'd0);
      chk($sformatf("%s c%0d Mdatain", tag, i), 64'(bus.Mdatain), 64'(exp_mdat));
`ifdef BUS_XFER_COUNT_EN
      if (c.done) exp_count = exp_count + 16'd1;
`endif
      @(posedge clk); #1;
    end
    check_idle(tag);
  endtask

  // Invariants, checked in every cycle away from the active edge.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      if (!$onehot0(bus.out_sel) || !$onehot0(bus.in_sel) || (bus.done && bus.err)) begin
        failures++;
        $display("FAIL invariant out_sel=%0h in_sel=%0h done=%0b err=%0b required onehot0/exclusive",
                 bus.out_sel, bus.in_sel, bus.done, bus.err);
      end
    end
  end

  // Watchdog.
  initial begin
`ifdef BUS_XFER_COUNT_EN
    #5ms;
`else
    #1ms;
`endif
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    logic [1:0]  r_op;
    logic [4:0]  r_src, r_dst;
    logic [31:0] r_data;
    int          t;

    // Stimulus table. Expected values are derived by hand from the transfer rules.
    tbl[0]  = '{2'd0, 5'd4,  5'd7,  32'd0,        1, mk(bit_at(4), bit_at(7), 0, 1, 0), mk('0, '0, 0, 0, 0), 32'd0};
    tbl[1]  = '{2'd1, 5'd0,  5'd4,  32'h00000024, 2, mk('0, bit_at(22), 1, 0, 0), mk(bit_at(22), bit_at(4), 0, 1, 0), 32'h24};
    tbl[2]  = '{2'd1, 5'd9,  5'd22, 32'hDEADBEEF, 1, mk('0, bit_at(22), 1, 1, 0), mk('0, '0, 0, 0, 0), 32'hDEADBEEF};
    tbl[3]  = '{2'd2, 5'd3,  5'd31, 32'd5,        1, mk(bit_at(3), '0, 0, 1, 0), mk('0, '0, 0, 0, 0), 32'hDEADBEEF};
    tbl[4]  = '{2'd3, 5'd1,  5'd2,  32'd6,        1, mk('0, '0, 0, 0, 1), mk('0, '0, 0, 0, 0), 32'hDEADBEEF};
    tbl[5]  = '{2'd0, 5'd27, 5'd1,  32'd7,        1, mk('0, '0, 0, 0, 1), mk('0, '0, 0, 0, 0), 32'hDEADBEEF};
    tbl[6]  = '{2'd0, 5'd5,  5'd5,  32'd8,        1, mk(bit_at(5), bit_at(5), 0, 1, 0), mk('0, '0, 0, 0, 0), 32'hDEADBEEF};
    tbl[7]  = '{2'd0, 5'd0,  5'd26, 32'd9,        1, mk(bit_at(0), bit_at(26), 0, 1, 0), mk('0, '0, 0, 0, 0), 32'hDEADBEEF};
    tbl[8]  = '{2'd2, 5'd26, 5'd0,  32'd10,       1, mk(bit_at(26), '0, 0, 1, 0), mk('0, '0, 0, 0, 0), 32'hDEADBEEF};
    tbl[9]  = '{2'd2, 5'd31, 5'd0,  32'd11,       1, mk('0, '0, 0, 0, 1), mk('0, '0, 0, 0, 0), 32'hDEADBEEF};
    tbl[10] = '{2'd1, 5'd31, 5'd26, 32'h12345678, 2, mk('0, bit_at(22), 1, 0, 0), mk(bit_at(22), bit_at(26), 0, 1, 0), 32'h12345678};
    tbl[11] = '{2'd1, 5'd0,  5'd27, 32'h55555555, 1, mk('0, '0, 0, 0, 1), mk('0, '0, 0, 0, 0), 32'h12345678};
    tbl[12] = '{2'd0, 5'd2,  5'd31, 32'd12,       1, mk('0, '0, 0, 0, 1), mk('0, '0, 0, 0, 0), 32'h12345678};

    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_src = '0; bus.req_dst = '0; bus.req_data = '0;
    reset = 1'b1;
    exp_mdat = 32'd0;
    exp_count = 16'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_idle("reset");

    // Table-driven vectors.
    for (int i = 0; i < 13; i++) begin
      exp_mdat = tbl[i].mdat;
      exp_q.push_back(tbl[i].c0);
      if (tbl[i].ncyc == 2) exp_q.push_back(tbl[i].c1);
      run_req($sformatf("tbl%0d", i), tbl[i].op, tbl[i].src, tbl[i].dst, tbl[i].data);
    end

    // Reset takes priority over an accept on the same edge.
    bus.req_valid = 1'b1; bus.req_op = 2'd0; bus.req_src = 5'd1; bus.req_dst = 5'd2;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; bus.req_valid = 1'b0;
    exp_mdat = 32'd0; exp_count = 16'd0;
    check_idle("rst_prio e1");
    @(posedge clk); #1;
    check_idle("rst_prio e2");

    // Reset during LOADA abandons LOADB.
    bus.req_valid = 1'b1; bus.req_op = 2'd1; bus.req_dst = 5'd4; bus.req_data = 32'hA5A5A5A5;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rst_loada Read", 64'(bus.Read), 64'd1);
    chk("rst_loada in_sel", 64'(bus.in_sel), 64'(bit_at(22)));
    chk("rst_loada Mdatain", 64'(bus.Mdatain), 64'hA5A5A5A5);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_mdat = 32'd0;
    check_idle("rst_loada e1");
    @(posedge clk); #1;
    check_idle("rst_loada e2");

`ifdef BUS_XFER_COUNT_EN
    // 65536 MOVEs starting from 0 must wrap the counter back to 0.
    for (int i = 0; i < 65536; i++) begin
      t = 0;
      while (bus.req_ready !== 1'b1 && t < 10) begin
        @(posedge clk); #1; t++;
      end
      bus.req_valid = 1'b1; bus.req_op = 2'd0; bus.req_src = 5'd1; bus.req_dst = 5'd2;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      if (i == 0) chk("wrap first", 64'(bus.xfer_count), 64'd1);
    end
    chk("wrap count", 64'(bus.xfer_count), 64'd0);
`endif

    // Randomized requests against the reference model.
    for (int i = 0; i < 60; i++) begin
      r_op   = 2'($urandom_range(0, 3));
      r_src  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(27, 31)) : 5'($urandom_range(0, 26));
      r_dst  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(27, 31)) : 5'($urandom_range(0, 26));
      if ($urandom_range(0, 7) == 0) r_dst = 5'd22;
      r_data = $urandom;
      model(r_op, r_src, r_dst, r_data);
      run_req($sformatf("rnd%0d op%0d s%0d d%0d", i, r_op, r_src, r_dst), r_op, r_src, r_dst, r_data);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
